// File: rtl/cen_pkg.sv
// Shared types and limits for the fractional clock-enable generator.
// The sequencer state enum is also exported on the top-level debug port.
package cen_pkg;

    localparam int CEN_W   = 16;
    localparam int MAX_NCH = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

endpackage

// File: rtl/frac_cen_chan.sv
// One fractional enable channel: an accumulator that produces num pulses per den cycles.
// cen is registered, so a decision taken in one cycle is visible in the next one.
module frac_cen_chan
    import cen_pkg::*;
#(
    parameter int W       = CEN_W,
    parameter int DEF_NUM = 1,
    parameter int DEF_DEN = 8
) (
    input  logic         refclk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         wr,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         cen
);

    localparam logic [W-1:0] RST_NUM = W'(DEF_NUM);
    localparam logic [W-1:0] RST_DEN = W'(DEF_DEN);

    logic [W-1:0] num_q;
    logic [W-1:0] den_q;
    logic [W-1:0] acc;
    logic [W:0]   sum;

    // One extra bit so acc+num never wraps before it is compared with den.
    assign sum = {1'b0, acc} + {1'b0, num_q};

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= RST_NUM;
            den_q <= RST_DEN;
            acc   <= '0;
            cen   <= 1'b0;
        end else if (wr) begin
            num_q <= num;
            den_q <= den;
            acc   <= '0;
            cen   <= 1'b0;
        end else if (!run || den_q == '0) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (num_q == '0) begin
            cen <= 1'b0;
        end else if (num_q >= den_q) begin
            acc <= '0;
            cen <= 1'b1;
        end else if (sum >= {1'b0, den_q}) begin
            acc <= W'(sum - {1'b0, den_q});
            cen <= 1'b1;
        end else begin
            acc <= sum[W-1:0];
            cen <= 1'b0;
        end
    end

endmodule

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator behind the core PLL.
// A lock sequencer keeps all enables low until pll_locked has been stable for LOCK_DLY cycles.
module frac_cen_gen
    import cen_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int W        = CEN_W,
    parameter int LOCK_DLY = 1024,
    parameter int DEF_NUM  = 1,
    parameter int DEF_DEN  = 8
) (
    input  logic           refclk,
    input  logic           rst_n,
    input  logic           pll_locked,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_ch,
    input  logic [W-1:0]   cfg_num,
    input  logic [W-1:0]   cfg_den,
    output logic [NCH-1:0] cen,
    output logic           ready,
    output logic [1:0]     dbg_state
);

    localparam int CNT_W = (LOCK_DLY > 1) ? $clog2(LOCK_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DLY - 1);

    logic             lk_s1;
    logic             lk_s;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [NCH-1:0]   wr;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_s1 <= 1'b0;
            lk_s  <= 1'b0;
        end else begin
            lk_s1 <= pll_locked;
            lk_s  <= lk_s1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == CNT_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // Gating on lk_s too lets the channels drop cen on the same edge the sequencer leaves RUN.
    assign run = (state == RUN) && lk_s;

    // cfg_we is a fire-and-forget strobe: no ready, accepted in every state, and
    // indices at or above NCH match no channel and are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            assign wr[gi] = cfg_we && (cfg_ch == 3'(gi));

            frac_cen_chan #(
                .W       (W),
                .DEF_NUM (DEF_NUM),
                .DEF_DEN (DEF_DEN)
            ) u_chan (
                .refclk (refclk),
                .rst_n  (rst_n),
                .run    (run),
                .wr     (wr[gi]),
                .num    (cfg_num),
                .den    (cfg_den),
                .cen    (cen[gi])
            );
        end
    endgenerate

endmodule
